vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_wr_fifo.sv | 61 ++++++
 rtl/vga_fb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter: default display size,
// host write FIFO geometry and the arbiter state encoding.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int V_DISPLAY_DEF = 480;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_wr_fifo.sv
// Four-entry host write FIFO holding {address, data}; push is ignored when
// full and pop is ignored when empty, so count never leaves 0..FIFO_DEPTH.
module vga_wr_fifo
    import vga_pkg::*;
#(
    parameter int WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_r [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_r;
    logic [FIFO_PTR_W-1:0] rd_ptr_r;
    logic [FIFO_CNT_W-1:0] count_r;
    logic                  push_s;
    logic                  pop_s;

    assign push_s = push && (count_r < FIFO_CNT_W'(FIFO_DEPTH));
    assign pop_s  = pop && (count_r != FIFO_CNT_W'(0));
    assign dout   = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Entry storage, cleared on reset so no stale data survives a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= FIFO_PTR_W'(0);
            rd_ptr_r <= FIFO_PTR_W'(0);
            count_r  <= FIFO_CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
                2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads win whenever video_on is
// high; buffered host writes drain during blanking. Optional macro
// VGA_FB_STALL_CNT_EN adds a saturating host stall counter output.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb,
    output logic              rgb_valid,
    output logic              err_oob
`ifdef VGA_FB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int          ENTRY_W = ADDR_W + DATA_W;
    localparam logic [31:0] H_LIM   = 32'(H_DISPLAY);
    localparam logic [31:0] V_LIM   = 32'(V_DISPLAY);

    vga_state_e            state_r;
    vga_state_e            next_state_s;
    logic [FIFO_CNT_W-1:0] count_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [ENTRY_W-1:0]    entry_s;
    logic [ADDR_W-1:0]     disp_addr_s;
    logic [ADDR_W-1:0]     host_addr_s;
    logic                  accept_s;
    logic                  oob_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  re_s;
    logic                  we_s;
    logic [ADDR_W-1:0]     addr_s;
    logic [DATA_W-1:0]     wdata_s;

    logic                  mem_re_r;
    logic                  mem_we_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [DATA_W-1:0]     mem_wdata_r;
    logic                  rd_pend_r;
    logic [DATA_W-1:0]     rgb_r;
    logic                  rgb_valid_r;
    logic                  err_oob_r;

    assign disp_addr_s = ADDR_W'(32'(pixel_y) * H_LIM + 32'(pixel_x));
    assign host_addr_s = ADDR_W'(32'(wr_y) * H_LIM + 32'(wr_x));
    assign oob_s       = (32'(wr_x) >= H_LIM) || (32'(wr_y) >= V_LIM);
    assign wr_ready    = (count_s < FIFO_CNT_W'(FIFO_DEPTH));
    assign accept_s    = wr_valid && wr_ready;
    assign push_s      = accept_s && !oob_s;
    assign entry_s     = {host_addr_s, wr_data};

    vga_wr_fifo #(
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_s),
        .dout  (head_s),
        .count (count_s)
    );

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: display preempts everything, otherwise drain until empty.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_DISP, ST_DRAIN: begin
                if (video_on) begin
                    next_state_s = ST_DISP;
                end else if (count_s != FIFO_CNT_W'(0)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Memory command for the cycle being entered; read and write are exclusive.
    always_comb begin
        pop_s   = 1'b0;
        re_s    = 1'b0;
        we_s    = 1'b0;
        addr_s  = {ADDR_W{1'b0}};
        wdata_s = {DATA_W{1'b0}};
        case (next_state_s)
            ST_DISP: begin
                re_s   = 1'b1;
                addr_s = disp_addr_s;
            end
            ST_DRAIN: begin
                pop_s   = 1'b1;
                we_s    = 1'b1;
                addr_s  = head_s[ENTRY_W-1:DATA_W];
                wdata_s = head_s[DATA_W-1:0];
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Registered memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_re_r    <= re_s;
            mem_we_r    <= we_s;
            mem_addr_r  <= addr_s;
            mem_wdata_r <= wdata_s;
        end
    end

    // Read return: data arrives one cycle after mem_re and is registered once more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_r   <= 1'b0;
            rgb_r       <= {DATA_W{1'b0}};
            rgb_valid_r <= 1'b0;
        end else begin
            rd_pend_r   <= mem_re_r;
            rgb_valid_r <= rd_pend_r;
            rgb_r       <= rd_pend_r ? mem_rdata : {DATA_W{1'b0}};
        end
    end

    // Sticky out-of-range write flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_oob_r <= 1'b0;
        end else if (accept_s && oob_s) begin
            err_oob_r <= 1'b1;
        end
    end

    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rgb       = rgb_r;
    assign rgb_valid = rgb_valid_r;
    assign err_oob   = err_oob_r;

`ifdef VGA_FB_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Host stall counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (wr_valid && !wr_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter against a queue-based
// reference model plus a behavioural single-port frame-buffer memory.
module tb_vga_fb_arbiter;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int DW = 12;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    pixel_x, pixel_y, wr_x, wr_y;
    logic          video_on, wr_valid, wr_ready;
    logic [DW-1:0] wr_data, mem_wdata, mem_rdata, rgb;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we, rgb_valid, err_oob;
`ifdef VGA_FB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    vga_fb_arbiter #(.H_DISPLAY(H), .V_DISPLAY(V), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rgb(rgb), .rgb_valid(rgb_valid), .err_oob(err_oob)
`ifdef VGA_FB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int qa[$];
    int qd[$];
    int img[int];
    bit m_err;
    int m_stall;
    bit pv[2];
    int pd[2];
    bit exp_re, exp_we, exp_rgbv;
    int exp_addr, exp_wdata, exp_rgb;

    // environment memory
    int env_mem[int];
    bit prev_re;
    int prev_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        qa.delete();
        qd.delete();
        m_err = 1'b0;
        m_stall = 0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        pd[0] = 0; pd[1] = 0;
        exp_re = 1'b0; exp_we = 1'b0; exp_rgbv = 1'b0;
        exp_addr = 0; exp_wdata = 0; exp_rgb = 0;
    endfunction

    function automatic void model_step();
        bit ready;
        int a;
        if (rst) begin
            model_reset();
            return;
        end
        ready = (qa.size() < 4);
        exp_rgbv = pv[1];
        exp_rgb  = pv[1] ? pd[1] : 0;
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = 1'b0;  pd[0] = 0;
        exp_re = 1'b0;
        exp_we = 1'b0;
        if (video_on) begin
            a = (int'(pixel_y) * H + int'(pixel_x)) % (1 << AW);
            exp_re = 1'b1;
            exp_addr = a;
            pv[0] = 1'b1;
            pd[0] = img.exists(a) ? img[a] : 0;
        end else if (qa.size() > 0) begin
            exp_we = 1'b1;
            exp_addr = qa.pop_front();
            exp_wdata = qd.pop_front();
            img[exp_addr] = exp_wdata;
        end
        if (wr_valid && ready) begin
            if (int'(wr_x) >= H || int'(wr_y) >= V) begin
                m_err = 1'b1;
            end else begin
                qa.push_back((int'(wr_y) * H + int'(wr_x)) % (1 << AW));
                qd.push_back(int'(wr_data));
            end
        end
        if (wr_valid && !ready && m_stall < 65535) m_stall++;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("mem_re", mem_re, exp_re);
        check_eq("mem_we", mem_we, exp_we);
        check_eq("re_we_excl", mem_re & mem_we, 1'b0);
        if (exp_re || exp_we) check_eq("mem_addr", mem_addr, exp_addr);
        if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
        check_eq("rgb_valid", rgb_valid, exp_rgbv);
        check_eq("rgb", rgb, exp_rgb);
        check_eq("wr_ready", wr_ready, qa.size() < 4);
        check_eq("err_oob", err_oob, m_err);
`ifdef VGA_FB_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, m_stall);
`endif
        // memory returns read data one cycle after mem_re; otherwise junk
        if (prev_re) mem_rdata = DW'(env_mem.exists(prev_addr) ? env_mem[prev_addr] : 0);
        else         mem_rdata = DW'($urandom);
        if (mem_we) env_mem[int'(mem_addr)] = int'(mem_wdata);
        prev_re = mem_re;
        prev_addr = int'(mem_addr);
    endtask

    task automatic set_in(input bit vo, input int px, input int py,
                          input bit wv, input int wx, input int wy, input int wd);
        video_on = vo;
        pixel_x = 10'(px); pixel_y = 10'(py);
        wr_valid = wv;
        wr_x = 10'(wx); wr_y = 10'(wy); wr_data = DW'(wd);
    endtask

    int ex[4];
    int ey[4];
    int ed[4];
    bit vo_r;

    initial begin
        model_reset();
        prev_re = 1'b0;
        prev_addr = 0;
        mem_rdata = '0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // single host write, then display read of the same pixel
        set_in(0, 0, 0, 1, 5, 2, 12'hABC);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        set_in(1, 5, 2, 0, 0, 0, 0);
        cycle();
        check_eq("read_re", mem_re, 1'b1);
        check_eq("read_addr", mem_addr, 32'd1285);
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        check_eq("read_rgb", rgb, 32'hABC);
        check_eq("read_rgb_valid", rgb_valid, 1'b1);
        cycle();

        // four writes buffered during display, drained in order at blanking
        for (int i = 0; i < 4; i++) begin
            ex[i] = $urandom_range(0, H - 1); ey[i] = $urandom_range(0, V - 1);
            ed[i] = $urandom_range(0, 4095);
            set_in(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1, ex[i], ey[i], ed[i]);
            cycle();
            check_eq("disp_no_we", mem_we, 1'b0);
        end
        check_eq("full_not_ready", wr_ready, 1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("drain_we", mem_we, 1'b1);
            check_eq("drain_addr", mem_addr, ey[i] * H + ex[i]);
            check_eq("drain_data", mem_wdata, ed[i]);
        end
        cycle();
        check_eq("drain_done", mem_we, 1'b0);

        // out-of-range write is dropped and flagged
        set_in(0, 0, 0, 1, 640, 0, 12'h123);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("oob_no_we", mem_we, 1'b0);
            check_eq("oob_sticky", err_oob, 1'b1);
        end

        // full FIFO with wr_valid held through blanking
        for (int i = 0; i < 4; i++) begin
            set_in(1, 10, 10, 1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 4095));
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 4095));
            cycle();
            if (i == 0) check_eq("slot_freed", wr_ready, 1'b1);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle();

        // drain aborted by video_on after two of three pops
        for (int i = 0; i < 3; i++) begin
            ex[i] = $urandom_range(0, H - 1); ey[i] = $urandom_range(0, V - 1);
            ed[i] = $urandom_range(0, 4095);
            set_in(1, 20, 20, 1, ex[i], ey[i], ed[i]);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        set_in(1, 30, 30, 0, 0, 0, 0);
        cycle();
        check_eq("abort_no_we", mem_we, 1'b0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_eq("resume_we", mem_we, 1'b1);
        check_eq("resume_addr", mem_addr, ey[2] * H + ex[2]);
        for (int i = 0; i < 3; i++) cycle();

        // asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) begin
            set_in(1, 40, 40, 1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 4095));
            cycle();
        end
        set_in(0, 0, 0, 1, 700, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_we", mem_we, 1'b0);
        check_eq("rst_re", mem_re, 1'b0);
        check_eq("rst_ready", wr_ready, 1'b1);
        check_eq("rst_err", err_oob, 1'b0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        check_eq("post_rst_no_we", mem_we, 1'b0);

        // four accepted then five stalled writes during display
        for (int i = 0; i < 9; i++) begin
            set_in(1, 50, 50, 1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 4095));
            cycle();
        end
`ifdef VGA_FB_STALL_CNT_EN
        check_eq("stall_five", stall_cnt, 32'd5);
`endif
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle();

        // randomized traffic
        vo_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) vo_r = ~vo_r;
            set_in(vo_r, $urandom_range(0, H - 1), $urandom_range(0, V - 1),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 31) == 0) ? $urandom_range(H, 1023) : $urandom_range(0, H - 1),
                   ($urandom_range(0, 31) == 0) ? $urandom_range(V, 1023) : $urandom_range(0, V - 1),
                   $urandom_range(0, 4095));
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
